fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
// Shares the single write port of tt_um_fifo among NUM_REQ producers with round-robin fairness.
// Each producer offers bursts over a valid/ready handshake and holds the port until its burst ends.
// Sits between the producers and the FIFO write side; honours fifo_full back-pressure.
// Idle owners cannot hold the port indefinitely.
// PARAMETERS
// NUM_REQ    4   number of requesters (2..8)
// DATA_W     8   FIFO data width
// BURST_MAX  4   max beats per grant before forced rotation (>=1)
// IDLE_TO    8   cycles owner may hold valid low mid-burst before forced release (>=1)
// PORTS
// clk           in   1                clock
// rst_n         in   1                reset; asynchronous, active-low
// req_valid     in   NUM_REQ          per-requester beat valid
// req_last      in   NUM_REQ          per-requester last beat of burst (qualified by valid)
// req_data      in   NUM_REQ*DATA_W   per-requester data; requester i at [i*DATA_W +: DATA_W]
// req_ready     out  NUM_REQ          beat accepted this cycle (one-hot or zero)
// fifo_full     in   1                FIFO cannot accept a write this cycle
// fifo_wr_en    out  1                write strobe to FIFO
// fifo_wr_data  out  DATA_W           write data to FIFO
// grant_id      out  $clog2(NUM_REQ)  current/last owner index
// busy          out  1                a requester owns the port (state XFER)
// BEHAVIOUR
// - Reset (async): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, idle_cnt=0; busy=0, fifo_wr_en=0, req_ready=0.
// - IDLE: if any req_valid, owner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ;
//   register grant_id=owner, go XFER. One-cycle arbitration bubble; no beat moves in IDLE.
// - XFER: beat = req_valid[owner] & ~fifo_full. Combinational: fifo_wr_en=beat, req_ready[owner]=beat,
//   fifo_wr_data=req_data[owner]. fifo_wr_data=0 when not XFER; other req_ready bits always 0.
// - Per beat: burst_cnt++ , idle_cnt=0. Release when beat & (req_last[owner] | burst_cnt==BURST_MAX-1).
// - Cycle with req_valid[owner]=0: idle_cnt++; release when idle_cnt==IDLE_TO-1. Cycles stalled by
//   fifo_full with valid high do NOT count toward idle_cnt or burst_cnt.
// - Release: state->IDLE, rr_ptr=owner+1 mod NUM_REQ, burst_cnt=0, idle_cnt=0; grant_id retains value.
// - Forced rotation (BURST_MAX) with no last: owner re-competes in IDLE at lowest priority.
// - fifo_full and req_last same cycle: no beat, no release; burst continues when full deasserts.
// - Requesters other than owner see ready=0 and must hold valid/data; no beat dropped or duplicated.
// - Reset mid-burst: outputs drop immediately; partial burst in FIFO is the producer's concern.
// - Counters sized $clog2(max(BURST_MAX,IDLE_TO))+1; no wrap possible before release.
// STRUCTURE
// - fifo_arb_pkg: state enum {IDLE, XFER}, width helper function, default parameter constants.
// - Sub-module rr_pick: combinational rotating-priority encoder (req vector, base ptr -> idx, found).
// - Top: FSM, rr_ptr/grant_id regs, burst_cnt, idle_cnt, data mux. Single clock domain.
// TESTING
// 1 Reset: rst_n=0 with all valid=1 -> busy=0, fifo_wr_en=0, req_ready=0, grant_id=0.
// 2 Round-robin: valid=4'b1111, last=1 every beat -> grants 0,1,2,3,0 each with a 1-cycle bubble.
// 3 Burst cap: req0 sends 6 beats, no last, req2 valid -> 4 beats of req0, then req2 granted, then req0's 2 remaining beats.
// 4 Back-pressure: fifo_full=1 for 5 cycles mid-burst -> no write, no ready, owner kept; burst resumes, beat count exact.
// 5 Idle timeout: owner drops valid 8 cycles mid-burst -> released, rr_ptr=owner+1; waiting req1 granted next IDLE.
// 6 Async reset mid-XFER: rst_n falls between clock edges -> fifo_wr_en, busy fall without clock; clean restart from req0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE = arbitration bubble, XFER = owned)
//   DEF_*       : default parameter values used by the arbiter modules
//   cnt_width   : width of the burst/idle counters, wide enough that neither
//                 counter can wrap before the release condition fires
//   wrap_add    : (a + b) mod n, used for rotating-priority indexing
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_MAX = 4;
    localparam int DEF_IDLE_TO   = 8;

    function automatic int cnt_width(input int burst_max, input int idle_to);
        int m;
        m = (burst_max > idle_to) ? burst_max : idle_to;
        return $clog2(m) + 1;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Returns the first set bit of req
// found when scanning base, base+1, ... (mod NUM_REQ).
//   req   in  NUM_REQ          request vector
//   base  in  $clog2(NUM_REQ)  index with highest priority
//   idx   out $clog2(NUM_REQ)  selected index (0 when nothing found)
//   found out 1                at least one request bit set
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     base,
    output logic [IDW-1:0]     idx,
    output logic               found
);

    always_comb begin
        logic [IDW-1:0] pos;
        pos   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = IDW'(wrap_add(int'(base), k, NUM_REQ));
            if (!found && req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A granted producer keeps the port for a whole burst (until req_last), but
// is forced off after BURST_MAX beats or after IDLE_TO consecutive cycles
// with its valid low. fifo_full stalls the owner without consuming either
// budget. Every grant costs one arbitration cycle (IDLE) with no beat.
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     per-requester beat valid
//   req_last      per-requester last-beat flag (qualified by valid)
//   req_data      per-requester data, requester i at [i*DATA_W +: DATA_W]
//   req_ready     beat accepted this cycle (one-hot or zero)
//   fifo_full     FIFO cannot accept a write this cycle
//   fifo_wr_en    FIFO write strobe
//   fifo_wr_data  FIFO write data (zero outside XFER)
//   grant_id      current / most recent owner
//   busy          a requester owns the port
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int IDLE_TO   = DEF_IDLE_TO
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = cnt_width(BURST_MAX, IDLE_TO);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX - 1);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_TO - 1);

    arb_state_t     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;
    logic [IDW-1:0] next_ptr;
    logic [CW-1:0]  burst_cnt;
    logic [CW-1:0]  idle_cnt;

    logic in_xfer;
    logic owner_valid;
    logic owner_last;
    logic beat;
    logic rel_burst;
    logic rel_idle;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .base  (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign in_xfer     = (state == XFER);
    assign owner_valid = req_valid[grant_id];
    assign owner_last  = req_last[grant_id];

    // A stalled cycle (full with valid high) is neither a beat nor an idle cycle.
    assign beat      = in_xfer & owner_valid & ~fifo_full;
    assign rel_burst = beat & (owner_last | (burst_cnt == BURST_LAST));
    assign rel_idle  = in_xfer & ~owner_valid & (idle_cnt == IDLE_LAST);

    // The releasing owner drops to lowest priority for the next arbitration.
    assign next_ptr = IDW'(wrap_add(int'(grant_id), 1, NUM_REQ));

    assign busy       = in_xfer;
    assign fifo_wr_en = beat;

    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = beat;
        fifo_wr_data        = '0;
        if (in_xfer) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id == IDW'(i)) begin
                    fifo_wr_data = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    idle_cnt  <= '0;
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (rel_burst || rel_idle) begin
                        state     <= IDLE;
                        rr_ptr    <= next_ptr;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                    end else if (beat) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        idle_cnt  <= '0;
                    end else if (!owner_valid) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
